// File: rtl/sc_max7219_pkg.sv
// Shared constants for the MAX7219 scan driver: register map, init data,
// FSM encoding and the word builder used for every transmitted 16-bit word.
package sc_max7219_pkg;

  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_DISPTEST  = 4'hF;

  localparam logic [7:0] DATA_DECODE    = 8'h00;
  localparam logic [7:0] DATA_SCANLIM   = 8'h07;
  localparam logic [7:0] DATA_SHUTDOWN  = 8'h01;
  localparam logic [7:0] DATA_DISPTEST  = 8'h00;

  localparam logic [3:0] INIT_WORDS = 4'd5;
  localparam logic [3:0] LAST_INDEX = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_LATCH
  } state_e;

  // Indices 0..4 are the init words, 5..12 map to digit registers 1..8.
  function automatic logic [15:0] word_of(input logic [3:0]  idx,
                                          input logic [3:0]  intensity,
                                          input logic [63:0] rows);
    logic [2:0]  row;
    logic [15:0] w;
    row = 3'(idx - INIT_WORDS);
    case (idx)
      4'd0:    w = {4'h0, ADDR_DECODE,    DATA_DECODE};
      4'd1:    w = {4'h0, ADDR_INTENSITY, 4'h0, intensity};
      4'd2:    w = {4'h0, ADDR_SCANLIM,   DATA_SCANLIM};
      4'd3:    w = {4'h0, ADDR_SHUTDOWN,  DATA_SHUTDOWN};
      4'd4:    w = {4'h0, ADDR_DISPTEST,  DATA_DISPTEST};
      default: w = {4'h0, idx - 4'd4, rows[{row, 3'b000} +: 8]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sc_max7219_scan_if.sv
// Row/enable inputs and serial bus outputs of the MAX7219 scan driver.
interface sc_max7219_scan_if;
  logic [63:0] SC_MAX7219_rows_InBUS;
  logic        SC_MAX7219_enable_InHigh;
  logic        SC_MAX7219_din_Out;
  logic        SC_MAX7219_sclk_Out;
  logic        SC_MAX7219_load_Out;
  logic        SC_MAX7219_busy_Out;
  logic        SC_MAX7219_frameDone_Out;

  modport slave (
    input  SC_MAX7219_rows_InBUS, SC_MAX7219_enable_InHigh,
    output SC_MAX7219_din_Out, SC_MAX7219_sclk_Out, SC_MAX7219_load_Out,
           SC_MAX7219_busy_Out, SC_MAX7219_frameDone_Out
  );

  modport master (
    output SC_MAX7219_rows_InBUS, SC_MAX7219_enable_InHigh,
    input  SC_MAX7219_din_Out, SC_MAX7219_sclk_Out, SC_MAX7219_load_Out,
           SC_MAX7219_busy_Out, SC_MAX7219_frameDone_Out
  );
endinterface

// File: rtl/sc_max7219_tick.sv
// Half-period timer: reloads on every FSM state change and flags the last
// cycle of the current phase.
module sc_max7219_tick #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic phase_end_o
);
  localparam int CW = $clog2(HALF_PERIOD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = CW'(HALF_PERIOD - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign phase_end_o = (cnt_q == '0);

endmodule

// File: rtl/sc_max7219_scan.sv
// MAX7219 serial driver: sends the five init words once after reset, then
// refreshes digits 1..8 from a per-frame snapshot of the 64 row bits.
module sc_max7219_scan
  import sc_max7219_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4,
  parameter logic [3:0]  INTENSITY   = 4'hF
) (
  input  logic          SC_MAX7219_CLOCK_50,
  input  logic          SC_MAX7219_RESET_InLow,
  sc_max7219_scan_if.slave bus
);

  logic        clk;
  logic        rst_sync_q;
  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d;
  logic [63:0] snap_q, snap_d;
  logic        phase_end, tick_clr, en;
  logic        din_o, sclk_o, load_o, busy_o, done_o;

  assign clk = SC_MAX7219_CLOCK_50;
  assign en  = bus.SC_MAX7219_enable_InHigh;

  // Assert asynchronously, release on the next clock edge.
  always_ff @(posedge clk or negedge SC_MAX7219_RESET_InLow)
    if (!SC_MAX7219_RESET_InLow) rst_sync_q <= 1'b0;
    else                         rst_sync_q <= 1'b1;

  assign tick_clr = (state_d != state_q);

  sc_max7219_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk_i       (clk),
    .rst_ni      (rst_sync_q),
    .clr_i       (tick_clr),
    .phase_end_o (phase_end)
  );

  always_ff @(posedge clk or negedge rst_sync_q)
    if (!rst_sync_q) state_q <= ST_IDLE;
    else             state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (en) state_d = ST_START;
      ST_START:    state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_d = (bit_q == 4'd0) ? ST_HOLD : ST_SHIFT_LO;
      ST_HOLD:     if (phase_end) state_d = ST_LATCH;
      ST_LATCH:    if (phase_end) state_d = en ? ST_START : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sclk_o = 1'b0;
    load_o = 1'b1;
    din_o  = 1'b0;
    busy_o = 1'b1;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE:     busy_o = 1'b0;
      ST_START,
      ST_SHIFT_LO,
      ST_HOLD:     begin load_o = 1'b0; din_o = sh_q[15]; end
      ST_SHIFT_HI: begin load_o = 1'b0; din_o = sh_q[15]; sclk_o = 1'b1; end
      ST_LATCH:    begin din_o = sh_q[15]; done_o = phase_end && (idx_q == LAST_INDEX); end
      default:     busy_o = 1'b0;
    endcase
  end

  // Index advances as LATCH ends; the snapshot is taken with the word for index 5.
  always_comb begin
    logic [63:0] src;
    idx_d  = idx_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    snap_d = snap_q;
    src    = snap_q;
    if (state_q == ST_LATCH && phase_end)
      idx_d = (idx_q == LAST_INDEX) ? INIT_WORDS : idx_q + 4'd1;
    if (state_d == ST_START) begin
      if (idx_d == INIT_WORDS) begin
        src    = bus.SC_MAX7219_rows_InBUS;
        snap_d = bus.SC_MAX7219_rows_InBUS;
      end
      sh_d  = word_of(idx_d, INTENSITY, src);
      bit_d = 4'd15;
    end else if (state_q == ST_SHIFT_HI && phase_end && bit_q != 4'd0) begin
      sh_d  = {sh_q[14:0], 1'b0};
      bit_d = bit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_q)
    if (!rst_sync_q) begin
      idx_q  <= 4'd0;
      bit_q  <= 4'd0;
      sh_q   <= 16'd0;
      snap_q <= 64'd0;
    end else begin
      idx_q  <= idx_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      snap_q <= snap_d;
    end

  assign bus.SC_MAX7219_din_Out       = din_o;
  assign bus.SC_MAX7219_sclk_Out      = sclk_o;
  assign bus.SC_MAX7219_load_Out      = load_o;
  assign bus.SC_MAX7219_busy_Out      = busy_o;
  assign bus.SC_MAX7219_frameDone_Out = done_o;

endmodule

// File: tb/tb_sc_max7219_scan.sv
// Randomized bench for sc_max7219_scan: word-offset reference model, bus
// decoder/protocol checker and literal pins on init and digit words.
module tb_sc_max7219_scan;

  localparam int H  = 4;
  localparam int WP = 1 + 34 * H;
  localparam logic [3:0] INTENS = 4'hF;
  localparam logic [63:0] PAT = 64'h8040201008040201;

  logic clk, rst_n;
  sc_max7219_scan_if bus();

  sc_max7219_scan #(.HALF_PERIOD(H), .INTENSITY(INTENS)) dut (
    .SC_MAX7219_CLOCK_50    (clk),
    .SC_MAX7219_RESET_InLow (rst_n),
    .bus                    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  logic din, sclk, load, busy, fd;
  assign din  = bus.SC_MAX7219_din_Out;
  assign sclk = bus.SC_MAX7219_sclk_Out;
  assign load = bus.SC_MAX7219_load_Out;
  assign busy = bus.SC_MAX7219_busy_Out;
  assign fd   = bus.SC_MAX7219_frameDone_Out;

  logic [15:0] init_lit [5] = '{16'h0900, 16'h0A0F, 16'h0B07, 16'h0C01, 16'h0F00};
  logic [7:0]  pat_lit  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  function automatic logic [15:0] mk_word(input int idx, input logic [63:0] snap);
    case (idx)
      0:       return 16'h0900;
      1:       return {8'h0A, 4'h0, INTENS};
      2:       return 16'h0B07;
      3:       return 16'h0C01;
      4:       return 16'h0F00;
      default: return {4'h0, 4'(idx - 4), snap[8*(idx-5) +: 8]};
    endcase
  endfunction

  // Reference model: which word is on the wire and how far into it we are.
  logic        m_sync, m_busy;
  int          m_k, m_idx;
  logic [15:0] m_word;
  logic [63:0] m_snap;

  initial begin
    m_sync = 0; m_busy = 0; m_k = 0; m_idx = 0; m_word = 0; m_snap = 0;
    forever begin
      logic start;
      @(posedge clk);
      start = 1'b0;
      if (!rst_n) begin
        m_sync = 0; m_busy = 0; m_k = 0; m_idx = 0; m_snap = 0;
      end else if (!m_sync) begin
        m_sync = 1;
      end else if (m_busy) begin
        if (m_k == WP - 1) begin
          m_idx = (m_idx == 12) ? 5 : m_idx + 1;
          if (bus.SC_MAX7219_enable_InHigh) start = 1'b1;
          else m_busy = 0;
        end else m_k++;
      end else if (bus.SC_MAX7219_enable_InHigh) start = 1'b1;
      if (start) begin
        m_busy = 1; m_k = 0;
        if (m_idx == 5) m_snap = bus.SC_MAX7219_rows_InBUS;
        m_word = mk_word(m_idx, m_snap);
      end
    end
  end

  int   vectors = 0, errors = 0;
  int   phase = 0;
  logic to_flag = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge.
  int          cyc = 0, j, hi_run, edge_cnt, words_n, last_latch, last_fd;
  logic        to_seen = 0, gap, gap_fd, fd_seen, ff_frame, resume_pending;
  logic        prev_sclk, prev_load, prev_din, din_chk;
  logic        e_load, e_sclk, e_fd, e_din;
  logic [15:0] dec;

  initial begin
    {hi_run, edge_cnt, words_n, last_latch, last_fd} = '0;
    {gap, gap_fd, fd_seen, ff_frame, resume_pending} = 5'b11000;
    prev_sclk = 0; prev_load = 1; prev_din = 0; dec = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (to_flag && !to_seen) begin
        chk("wait_timeout", 32'(to_flag), 32'd0);
        to_seen = 1'b1;
      end
      if (!rst_n) begin
        chk("reset_outs", 32'({sclk, load, din, busy, fd}), 32'b01000);
        words_n = 0; edge_cnt = 0; hi_run = 0; gap = 1; gap_fd = 1;
        prev_sclk = 0; prev_load = 1; prev_din = 0;
      end else begin
        e_load = 1; e_sclk = 0; e_fd = 0; e_din = 0; din_chk = 1;
        if (m_busy) begin
          if (m_k == 0) begin
            e_load = 0; e_din = m_word[15];
          end else if (m_k <= 32*H) begin
            j = (m_k - 1) / H;
            e_load = 0; e_sclk = (j % 2) == 1; e_din = m_word[15 - j/2];
          end else if (m_k <= 33*H) begin
            e_load = 0; din_chk = 0;
          end else begin
            din_chk = 0; e_fd = (m_k == WP - 1) && (m_idx == 12);
          end
        end
        chk("ctrl_busy_load_sclk_done", 32'({busy, load, sclk, fd}),
            32'({m_busy, e_load, e_sclk, e_fd}));
        if (din_chk) chk("din", 32'(din), 32'(e_din));

        if (!busy) begin
          gap = 1; gap_fd = 1;
          if (phase == 3) resume_pending = 1;
        end
        if (sclk) hi_run++;
        if (prev_sclk && !sclk) begin
          chk("sclk_high_min", 32'(hi_run >= 4), 32'd1);
          hi_run = 0;
        end
        if (prev_load && !load) edge_cnt = 0;
        if (!prev_sclk && sclk && !load) begin
          edge_cnt++;
          dec = {dec[14:0], din};
          chk("din_stable", 32'(din), 32'(prev_din));
        end
        if (!prev_load && load) begin
          chk("edges16", 32'(edge_cnt), 32'd16);
          chk("word", 32'(dec), 32'(m_word));
          if (words_n < 5) begin
            chk("init_word_lit", 32'(dec), 32'(init_lit[words_n]));
            if (words_n > 0 && !gap) chk("init_spacing", 32'(cyc - last_latch), 32'(WP));
          end
          if ((phase == 1 || phase == 2) && dec[11:8] >= 4'd1 && dec[11:8] <= 4'd8) begin
            if (phase == 2 && dec[11:8] == 4'd1) ff_frame = 1;
            chk("digit_lit", 32'(dec[7:0]), ff_frame ? 32'hFF : 32'(pat_lit[dec[10:8] - 3'd1]));
          end
          if (resume_pending && phase == 4) begin
            chk("resume_addr", 32'(dec[11:8]), 32'd3);
            resume_pending = 0;
          end
          words_n++; last_latch = cyc; gap = 0;
        end
        if (fd) begin
          if ((phase == 1 || phase == 2) && !gap_fd && fd_seen)
            chk("frame_period", 32'(cyc - last_fd), 32'd1096);
          last_fd = cyc; fd_seen = 1; gap_fd = 0;
        end
        prev_sclk = sclk; prev_load = load; prev_din = din;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_model(input int idx, input int k, input int budget);
    int t;
    t = 0;
    while (!(m_busy && m_idx == idx && m_k == k) && t < budget) begin
      @(posedge clk); #1; t++;
    end
    if (t >= budget) to_flag = 1;
  endtask

  initial begin
    rst_n = 0;
    bus.SC_MAX7219_enable_InHigh = 1;
    bus.SC_MAX7219_rows_InBUS = PAT;
    cycles(3);
    rst_n = 1; phase = 1;
    cycles(5*WP + 16*WP + 50);
    wait_model(8, 60, 2000);
    bus.SC_MAX7219_rows_InBUS = '1; phase = 2;
    cycles(16*WP + 100);
    wait_model(6, 70, 1500);
    bus.SC_MAX7219_enable_InHigh = 0; phase = 3;
    cycles(WP + 300);
    bus.SC_MAX7219_enable_InHigh = 1; phase = 4;
    cycles(3*WP);
    phase = 5;
    rst_n = 0; cycles(2); rst_n = 1;
    wait_model(2, 45, 1000);
    rst_n = 0; cycles(3); rst_n = 1;
    cycles(6*WP);
    phase = 6;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(299) == 0)
        bus.SC_MAX7219_enable_InHigh = ~bus.SC_MAX7219_enable_InHigh;
      if ($urandom_range(199) == 0)
        bus.SC_MAX7219_rows_InBUS = {$urandom, $urandom};
      if ($urandom_range(2999) == 0) begin
        rst_n = 0; cycles(2); rst_n = 1;
      end
      cycles(1);
    end
    cycles(50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sc_max7219_scan.md
SC_MAX7219_SCAN -- requirements
Module: sc_max7219_scan

Interface
REQ-001 Parameter HALF_PERIOD, default 4, system-clock cycles per SCLK half-period (SCLK = 50 MHz / 8 = 6.25 MHz); legal range 2..255.
REQ-002 Parameter INTENSITY, default 4'hF, value written to the MAX7219 intensity register 0x0A.
REQ-003 SC_MAX7219_CLOCK_50  in  1  the single system clock, 50 MHz; all logic on its rising edge.
REQ-004 SC_MAX7219_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-005 SC_MAX7219_rows_InBUS  in  64  eight 8-bit point rows; row r occupies bits [8r+7:8r] and is sent to digit register r+1.
REQ-006 SC_MAX7219_enable_InHigh  in  1  high = run or continue transmission; low = stop at the next word boundary.
REQ-007 SC_MAX7219_din_Out  out  1  serial data to the MAX7219, MSB first.
REQ-008 SC_MAX7219_sclk_Out  out  1  serial clock; the device samples on the rising edge.
REQ-009 SC_MAX7219_load_Out  out  1  LOAD/CS; low while a word is shifted; a rising edge latches the word.
REQ-010 SC_MAX7219_busy_Out  out  1  high whenever the FSM is outside IDLE.
REQ-011 SC_MAX7219_frameDone_Out  out  1  one-cycle pulse after digit 8 has been latched.

Function
REQ-012 Word format: 16 bits, {4'h0, addr[3:0], data[7:0]}, shifted MSB first.
REQ-013 Word index 0..12 defines the transmission sequence.
- Indices 0..4 (init): 0x09/0x00, 0x0A/{4'h0,INTENSITY}, 0x0B/0x07, 0x0C/0x01, 0x0F/0x00.
- Indices 5..12: digit addr 0x01..0x08, each carrying snapshot row (index-5).
REQ-014 After index 12 the index wraps to 5; the init words are sent only once after each reset.
REQ-015 Snapshot: all 64 row bits are registered in the cycle that index-5 transmission begins; the frame uses only the snapshot, so no tearing occurs.
REQ-016 FSM states are IDLE, START, SHIFT_LO, SHIFT_HI, HOLD and LATCH.
REQ-017 IDLE -> START when enable is high.
REQ-018 START lasts 1 cycle: load=0; the word is loaded into the shift register; din=bit15.
REQ-019 SHIFT_LO lasts HALF_PERIOD cycles with sclk=0, then goes to SHIFT_HI.
REQ-020 SHIFT_HI lasts HALF_PERIOD cycles with sclk=1.
- After bits 15..1: shift, update din on the falling edge, go to SHIFT_LO.
- After bit 0: go to HOLD.
REQ-021 HOLD lasts HALF_PERIOD cycles with sclk=0 and load=0.
REQ-022 LATCH lasts HALF_PERIOD cycles with load=1; the index then advances.
- Enable high: go to START.
- Enable low: go to IDLE.
REQ-023 Word period = 1 + 34*HALF_PERIOD cycles (137 at default); a full refresh frame = 8 words = 1096 cycles.
REQ-024 frameDone pulses in the cycle LATCH for index 12 completes.
REQ-025 Enable deassert mid-word: the current word completes through LATCH; no word is ever truncated.
REQ-026 Resume after a stop continues at the saved index, including a partially completed init sequence.
REQ-027 In IDLE: sclk=0, load=1, din=0.
REQ-028 Rows changing during a frame have no effect until the next index-5 snapshot.
REQ-029 The half-period counter width is ceil(log2(HALF_PERIOD+1)); the bit counter is 4 bits; the index counter is 4 bits and never exceeds 12.

Reset
REQ-030 Asserting reset forces the following asynchronously, regardless of the clock:
- State IDLE, index 0, counters 0, snapshot 0.
- sclk=0, load=1, din=0, busy=0, frameDone=0.
REQ-031 Reset mid-word aborts the word immediately (load returns to 1); the full init sequence is re-sent after release.
REQ-032 Reset release is synchronous to the clock; the earliest START is the 2nd rising edge after release with enable high.

Structure
REQ-033 Shared package sc_max7219_pkg holds:
- Register addresses 0x09, 0x0A, 0x0B, 0x0C, 0x0F.
- Init data constants.
- The FSM state encoding.
- INIT_WORDS=5 and LAST_INDEX=12.
REQ-034 Sub-module sc_max7219_tick, a HALF_PERIOD down-counter, issues a phase-end pulse and is cleared on every state change.

Verification
REQ-035 Reset with enable=1, HALF_PERIOD=4: the first 5 decoded words are 0x0900, 0x0A0F, 0x0B07, 0x0C01, 0x0F00, each 137 cycles apart.
REQ-036 Rows = 64'h8040201008040201: digit words 0x0101, 0x0202, 0x0304, ..., 0x0880 are decoded; frameDone pulses once per 1096 cycles.
REQ-037 Change rows to all-0xFF in the middle of digit 4: digits 4..8 of that frame keep the old values; the next frame shows 0x01FF..0x08FF.
REQ-038 Drop enable during bit 7 of index 6: the word finishes with load rising, busy falls, and the bus stays idle. Re-raise enable: the next word is index 7 (addr 0x03).
REQ-039 Assert reset during bit 10 of index 2: load=1 and sclk=0 immediately. After release, the sequence restarts at 0x0900.
REQ-040 A protocol checker verifies on every word:
- Exactly 16 rising sclk edges while load=0.
- din stable across each rising edge.
- sclk high time >= 4 cycles.
